// File: rtl/rvb_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rvb_shifter_pipe
// Purpose  : Pipelined bitmanip shifter with valid/ready backpressure and an
//            in-order tag sideband. Computes shifts, rotates, funnel shifts
//            and optional single-bit ops. Word (W) ops are available on
//            XLEN=64 builds.
// Ports    : clock, reset        - rising-edge clock, sync active-high reset
//            din_valid/din_ready - input handshake
//            din_op, din_w       - opcode and word-op select
//            din_tag             - opaque tag returned with the result
//            din_rs1/rs2/rs3     - operand A, shift amount/index, funnel B
//            dout_valid/ready    - output handshake
//            dout_tag, dout_rd   - tag and result of the oldest operation
// Revision : 1.0 - initial release
// ============================================================================
module rvb_shifter_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 4,
  parameter int SBOP   = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [3:0]      din_op,
  input  logic            din_w,
  input  logic [TAGW-1:0] din_tag,
  input  logic [XLEN-1:0] din_rs1,
  input  logic [XLEN-1:0] din_rs2,
  input  logic [XLEN-1:0] din_rs3,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [TAGW-1:0] dout_tag,
  output logic [XLEN-1:0] dout_rd
);

  localparam logic [3:0] C_OP_SLL   = 4'd0;
  localparam logic [3:0] C_OP_SRL   = 4'd1;
  localparam logic [3:0] C_OP_SRA   = 4'd2;
  localparam logic [3:0] C_OP_SLO   = 4'd3;
  localparam logic [3:0] C_OP_SRO   = 4'd4;
  localparam logic [3:0] C_OP_ROL   = 4'd5;
  localparam logic [3:0] C_OP_ROR   = 4'd6;
  localparam logic [3:0] C_OP_FSL   = 4'd7;
  localparam logic [3:0] C_OP_FSR   = 4'd8;
  localparam logic [3:0] C_OP_SBSET = 4'd9;
  localparam logic [3:0] C_OP_SBCLR = 4'd10;
  localparam logic [3:0] C_OP_SBINV = 4'd11;
  localparam logic [3:0] C_OP_SBEXT = 4'd12;

  // The whole function is evaluated on a 64-bit container with an operating
  // width of 32 or 64 bits. Everything above the operating width is masked
  // off so that a 32-bit operation never leaks bits into the upper half.
  function automatic logic [63:0] shift_fn(
    input logic [3:0]  op,
    input logic        l64,
    input logic [63:0] a,
    input logic [6:0]  b,
    input logic [63:0] c
  );
    logic [63:0] mask, am, cm, fa, fb, onebit, r;
    logic [6:0]  len, sh, fs;
    logic        sign;
    mask   = l64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    len    = l64 ? 7'd64 : 7'd32;
    sh     = {1'b0, b[5:0] & (l64 ? 6'h3F : 6'h1F)};
    fs     = b & (l64 ? 7'h7F : 7'h3F);
    am     = a & mask;
    cm     = c & mask;
    sign   = l64 ? a[63] : a[31];
    onebit = 64'd1 << sh;
    // Funnel amount covers 2L; the upper half swaps the operands.
    fa = am;
    fb = cm;
    if (fs >= len) begin
      fa = cm;
      fb = am;
      fs = fs - len;
    end
    r = 64'd0;
    case (op)
      C_OP_SLL: r = am << sh;
      C_OP_SRL: r = am >> sh;
      C_OP_SRA: r = (am >> sh) | (sign ? (mask & ~(mask >> sh)) : 64'd0);
      C_OP_SLO: r = ~((~am & mask) << sh);
      C_OP_SRO: r = ~((~am & mask) >> sh);
      // A shift by len yields 0 here, which covers the sh==0 rotate case.
      C_OP_ROL: r = (am << sh) | (am >> (len - sh));
      C_OP_ROR: r = (am >> sh) | (am << (len - sh));
      C_OP_FSL: r = (fs == 7'd0) ? fa : ((fa << fs) | (fb >> (len - fs)));
      C_OP_FSR: r = (fs == 7'd0) ? fa : ((fa >> fs) | (fb << (len - fs)));
      C_OP_SBSET: r = (SBOP != 0) ? (am | onebit) : 64'd0;
      C_OP_SBCLR: r = (SBOP != 0) ? (am & ~onebit) : 64'd0;
      C_OP_SBINV: r = (SBOP != 0) ? (am ^ onebit) : 64'd0;
      C_OP_SBEXT: r = (SBOP != 0) ? ((am >> sh) & 64'd1) : 64'd0;
      default:  r = 64'd0;
    endcase
    return r & mask;
  endfunction

  logic [63:0]     w_raw;
  logic [XLEN-1:0] w_result;
  logic            w_wmode;

  // Only bits [6:0] of the shift amount matter for any operation.
  logic unused_rs2;
  assign unused_rs2 = &{1'b0, din_rs2[XLEN-1:7]};

  // Width selection and final sign extension depend on the datapath width.
  if (XLEN == 64) begin : g_x64
    assign w_wmode  = din_w;
    assign w_raw    = shift_fn(din_op, !w_wmode, 64'(din_rs1), din_rs2[6:0],
                               64'(din_rs3));
    assign w_result = w_wmode ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;
  end else begin : g_x32
    logic unused_x32;
    assign w_wmode    = 1'b0;
    assign w_raw      = shift_fn(din_op, 1'b0, 64'(din_rs1), din_rs2[6:0],
                                 64'(din_rs3));
    assign w_result   = w_raw[31:0];
    assign unused_x32 = &{1'b0, din_w, w_wmode, w_raw[63:32]};
  end

  // Stage chain. Stage 0 captures the finished result; later stages only
  // carry it. ready depends on registered valid bits and dout_ready only.
  logic [STAGES:0]   stg_ready;
  logic [STAGES-1:0] stg_valid;
  logic [XLEN-1:0]   stg_data [STAGES];
  logic [TAGW-1:0]   stg_tag  [STAGES];

  assign stg_ready[STAGES] = dout_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic            in_valid;
    logic [XLEN-1:0] in_data;
    logic [TAGW-1:0] in_tag;
    logic            r_valid;
    logic [XLEN-1:0] r_data;
    logic [TAGW-1:0] r_tag;

    if (i == 0) begin : g_first
      assign in_valid = din_valid;
      assign in_data  = w_result;
      assign in_tag   = din_tag;
    end else begin : g_next
      assign in_valid = stg_valid[i-1];
      assign in_data  = stg_data[i-1];
      assign in_tag   = stg_tag[i-1];
    end

    assign stg_ready[i] = !r_valid || stg_ready[i+1];
    assign stg_valid[i] = r_valid;
    assign stg_data[i]  = r_data;
    assign stg_tag[i]   = r_tag;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_tag   <= '0;
      end else if (stg_ready[i]) begin
        r_valid <= in_valid;
        // Payload only moves on an actual transfer so a drained stage keeps
        // its last value instead of picking up bubbles.
        if (in_valid) begin
          r_data <= in_data;
          r_tag  <= in_tag;
        end
      end
    end
  end

  assign din_ready  = stg_ready[0];
  assign dout_valid = stg_valid[STAGES-1];
  assign dout_rd    = stg_data[STAGES-1];
  assign dout_tag   = stg_tag[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_rvb_shifter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvb_shifter_pipe
// Purpose  : Scoreboard bench for rvb_shifter_pipe. One XLEN=32 instance
//            (SBOP=0) and one XLEN=64 instance (SBOP=1), both two stages.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvb_shifter_pipe;

  localparam int STAGES = 2;

  typedef struct {
    logic [63:0] rd;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // XLEN=32 instance signals
  logic        rst32, v32, rdy32, w32, ov32, or32;
  logic [3:0]  op32, tag32, otag32;
  logic [31:0] a32, b32, c32, ord32;
  // XLEN=64 instance signals
  logic        rst64, v64, rdy64, w64, ov64, or64;
  logic [3:0]  op64, tag64, otag64;
  logic [63:0] a64, b64, c64, ord64;

  exp_t q32[$];
  exp_t q64[$];
  int   acc32 = 0;
  bit   sender_done = 1'b1;

  rvb_shifter_pipe #(.XLEN(32), .STAGES(STAGES), .TAGW(4), .SBOP(0)) u32 (
    .clock(clock), .reset(rst32), .din_valid(v32), .din_ready(rdy32),
    .din_op(op32), .din_w(w32), .din_tag(tag32), .din_rs1(a32),
    .din_rs2(b32), .din_rs3(c32), .dout_valid(ov32), .dout_ready(or32),
    .dout_tag(otag32), .dout_rd(ord32)
  );

  rvb_shifter_pipe #(.XLEN(64), .STAGES(STAGES), .TAGW(4), .SBOP(1)) u64 (
    .clock(clock), .reset(rst64), .din_valid(v64), .din_ready(rdy64),
    .din_op(op64), .din_w(w64), .din_tag(tag64), .din_rs1(a64),
    .din_rs2(b64), .din_rs3(c64), .dout_valid(ov64), .dout_ready(or64),
    .dout_tag(otag64), .dout_rd(ord64)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitors: pop on every output transfer.
  always @(negedge clock) begin
    if (!rst32 && ov32 && or32) begin
      if (q32.size() == 0) begin
        check("u32_unexpected_output_tag", 64'(otag32), 64'hDEAD);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("u32_rd", 64'(ord32), e.rd);
        check("u32_tag", 64'(otag32), 64'(e.tag));
        if (e.lat) check("u32_latency", 64'(cyc - e.acc), 64'(STAGES));
      end
    end
  end

  always @(negedge clock) begin
    if (!rst64 && ov64 && or64) begin
      if (q64.size() == 0) begin
        check("u64_unexpected_output_tag", 64'(otag64), 64'hDEAD);
      end else begin
        exp_t e;
        e = q64.pop_front();
        check("u64_rd", ord64, e.rd);
        check("u64_tag", 64'(otag64), 64'(e.tag));
      end
    end
  end

  task automatic send32(input logic [3:0] op, input logic [3:0] tg,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] exp,
                        input bit lat);
    int  n = 0;
    bit  done = 1'b0;
    v32 = 1'b1; op32 = op; tag32 = tg; a32 = a; b32 = b; c32 = c; w32 = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (rdy32) begin
        done = 1'b1;
        acc32++;
        q32.push_back('{rd: 64'(exp), tag: tg, acc: cyc, lat: lat});
      end
      @(posedge clock); #1;
      n++;
      if (!done && n > 200) begin
        check("u32_accept_timeout", 64'(n), 64'd0);
        done = 1'b1;
      end
    end
    v32 = 1'b0;
  endtask

  task automatic send64(input logic [3:0] op, input logic wm,
                        input logic [3:0] tg, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] exp);
    int  n = 0;
    bit  done = 1'b0;
    v64 = 1'b1; op64 = op; w64 = wm; tag64 = tg; a64 = a; b64 = b; c64 = c;
    while (!done) begin
      @(negedge clock);
      if (rdy64) begin
        done = 1'b1;
        q64.push_back('{rd: exp, tag: tg, acc: cyc, lat: 1'b0});
      end
      @(posedge clock); #1;
      n++;
      if (!done && n > 200) begin
        check("u64_accept_timeout", 64'(n), 64'd0);
        done = 1'b1;
      end
    end
    v64 = 1'b0;
  endtask

  task automatic drain32();
    int n = 0;
    while ((q32.size() != 0 || !sender_done) && n < 100) begin
      @(posedge clock); n++;
    end
    repeat (3) @(posedge clock);
    #1;
    check("u32_pending_after_drain", 64'(q32.size()), 64'd0);
  endtask

  task automatic drain64();
    int n = 0;
    while (q64.size() != 0 && n < 100) begin
      @(posedge clock); n++;
    end
    repeat (3) @(posedge clock);
    #1;
    check("u64_pending_after_drain", 64'(q64.size()), 64'd0);
  endtask

  initial begin
    int base;
    rst32 = 1'b1; v32 = 1'b0; op32 = '0; tag32 = '0; w32 = 1'b0;
    a32 = '0; b32 = '0; c32 = '0; or32 = 1'b1;
    rst64 = 1'b1; v64 = 1'b0; op64 = '0; tag64 = '0; w64 = 1'b0;
    a64 = '0; b64 = '0; c64 = '0; or64 = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    rst32 = 1'b0; rst64 = 1'b0;
    @(negedge clock);
    check("reset_dout_valid", 64'(ov32), 64'd0);
    check("reset_din_ready", 64'(rdy32), 64'd1);
    check("reset_dout_rd", 64'(ord32), 64'd0);
    check("reset_dout_tag", 64'(otag32), 64'd0);
    check("reset64_dout_valid", 64'(ov64), 64'd0);
    @(posedge clock); #1;

    // Single op with latency check.
    send32(4'd0, 4'd5, 32'h1, 32'h24, 32'h0, 32'h10, 1'b1);
    drain32();

    // Shift/rotate/funnel set, back to back.
    send32(4'd2,  4'd1, 32'h80000000, 32'd31, 32'h0, 32'hFFFFFFFF, 1'b0);
    send32(4'd4,  4'd2, 32'h0000000F, 32'd4,  32'h0, 32'hF0000000, 1'b0);
    send32(4'd6,  4'd3, 32'h12345678, 32'd8,  32'h0, 32'h78123456, 1'b0);
    send32(4'd12, 4'd4, 32'hFFFFFFFF, 32'd0,  32'h0, 32'h00000000, 1'b0);
    send32(4'd7,  4'd5, 32'h12345678, 32'd8,  32'h9ABCDEF0, 32'h3456789A, 1'b0);
    send32(4'd7,  4'd6, 32'h12345678, 32'd40, 32'h9ABCDEF0, 32'hBCDEF012, 1'b0);
    send32(4'd8,  4'd7, 32'h12345678, 32'd0,  32'h9ABCDEF0, 32'h12345678, 1'b0);
    send32(4'd5,  4'd8, 32'h80000001, 32'd1,  32'h0, 32'h00000003, 1'b0);
    send32(4'd3,  4'd9, 32'h00000001, 32'd4,  32'h0, 32'h0000001F, 1'b0);
    send32(4'd14, 4'hA, 32'hFFFFFFFF, 32'd3,  32'hFFFFFFFF, 32'h0, 1'b0);
    drain32();

    // Backpressure: four ops, output blocked.
    or32 = 1'b0;
    base = acc32;
    sender_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 4; t++)
          send32(4'd0, 4'(t), 32'h1, 32'(t), 32'h0, 32'h1 << t, 1'b0);
        sender_done = 1'b1;
      end
    join_none
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("bp_accept_count", 64'(acc32 - base), 64'd2);
    check("bp_din_ready", 64'(rdy32), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_valid", 64'(ov32), 64'd1);
      check("bp_hold_tag", 64'(otag32), 64'd0);
      check("bp_hold_rd", 64'(ord32), 64'd1);
      @(negedge clock);
    end
    @(posedge clock); #1;
    or32 = 1'b1;
    drain32();

    // Reset with two ops in flight.
    or32 = 1'b0;
    send32(4'd0, 4'hB, 32'h1, 32'd1, 32'h0, 32'h2, 1'b0);
    send32(4'd0, 4'hC, 32'h1, 32'd2, 32'h0, 32'h4, 1'b0);
    rst32 = 1'b1;
    q32.delete();
    @(posedge clock); #1;
    rst32 = 1'b0;
    @(negedge clock);
    check("midrst_dout_valid", 64'(ov32), 64'd0);
    check("midrst_din_ready", 64'(rdy32), 64'd1);
    check("midrst_dout_rd", 64'(ord32), 64'd0);
    @(posedge clock); #1;
    or32 = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    send32(4'd6, 4'hD, 32'h12345678, 32'd8, 32'h0, 32'h78123456, 1'b0);
    drain32();

    // XLEN=64 with word ops and single-bit ops.
    send64(4'd0, 1'b1, 4'd0, 64'h0000000040000000, 64'd1, 64'd0,
           64'hFFFFFFFF80000000);
    send64(4'd0, 1'b0, 4'd1, 64'h0000000040000000, 64'd1, 64'd0,
           64'h0000000080000000);
    send64(4'd2, 1'b1, 4'd2, 64'h0000000080000000, 64'd4, 64'd0,
           64'hFFFFFFFFF8000000);
    send64(4'd6, 1'b0, 4'd3, 64'h0123456789ABCDEF, 64'd4, 64'd0,
           64'hF0123456789ABCDE);
    send64(4'd1, 1'b0, 4'd4, 64'h8000000000000000, 64'h43, 64'd0,
           64'h1000000000000000);
    send64(4'd9, 1'b0, 4'd5, 64'h0, 64'd40, 64'd0, 64'h0000010000000000);
    send64(4'd12, 1'b0, 4'd6, 64'h10, 64'd4, 64'd0, 64'h1);
    send64(4'd10, 1'b0, 4'd7, 64'hFF, 64'd0, 64'd0, 64'hFE);
    send64(4'd11, 1'b1, 4'd8, 64'h0, 64'd31, 64'd0, 64'hFFFFFFFF80000000);
    send64(4'd13, 1'b0, 4'd9, 64'hFFFF, 64'd1, 64'hFFFF, 64'h0);
    send64(4'd8, 1'b1, 4'hA, 64'h12345678, 64'd8, 64'h9ABCDEF0,
           64'hFFFFFFFFF0123456);
    drain64();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
